// File: rtl/floor_div_pow2_mc.sv
// Pipelined floor(x / 2^s) on IEEE-754 single-precision values.
// Three stages: decode, exponent/mask/sticky, floor increment and assembly.
module floor_div_pow2_mc #(
    parameter int NEG_FLOOR = 1,
    parameter int SHIFT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic        done,
    output logic [31:0] result
);

    // Wide enough that e - 127 - s never wraps for any shift amount.
    localparam int EW = ((SHIFT_W > 8) ? SHIFT_W : 8) + 2;
    localparam logic signed [EW-1:0] BIAS   = EW'(127);
    localparam logic signed [EW-1:0] E_TOP  = EW'(22);
    localparam logic signed [EW-1:0] M_BITS = EW'(23);
    localparam logic [31:0] NEG_ZERO = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE  = 32'hBF80_0000;

    typedef enum logic [1:0] {
        CL_ZERO = 2'd0,
        CL_NORM = 2'd1,
        CL_SPEC = 2'd2
    } cls_t;

    function automatic logic [31:0] floor_assemble(
        input logic        sgn,
        input logic [7:0]  expo,
        input logic [22:0] man,
        input logic        bump,
        input logic [23:0] unit
    );
        logic [24:0] sig;
        sig = {2'b01, man} + (bump ? {1'b0, unit} : 25'd0);
        if (sig[24]) begin
            return {sgn, expo + 8'd1, 23'd0};
        end
        return {sgn, expo, sig[22:0]};
    endfunction

    // ---- stage 1: operand decode
    logic               vld_p1_q;
    logic               sign_p1_q;
    logic [7:0]         exp_p1_q;
    logic [22:0]        man_p1_q;
    logic [SHIFT_W-1:0] shf_p1_q;
    cls_t               cls_p1_q;
    cls_t               cls_d;

    always_comb begin
        cls_d = CL_NORM;
        if (dataa[30:23] == 8'hFF) begin
            cls_d = CL_SPEC;
        end else if (dataa[30:23] == 8'h00) begin
            cls_d = CL_ZERO;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1_q <= 1'b0;
        end else if (clk_en) begin
            vld_p1_q <= start;
        end
    end

    always_ff @(posedge clk) begin
        if (clk_en && start) begin
            sign_p1_q <= dataa[31];
            exp_p1_q  <= dataa[30:23];
            man_p1_q  <= dataa[22:0];
            shf_p1_q  <= datab[SHIFT_W-1:0];
            cls_p1_q  <= cls_d;
        end
    end

    // ---- stage 2: unbiased exponent, truncation mask, sticky
    logic signed [EW-1:0] exp_ext;
    logic signed [EW-1:0] shf_ext;
    logic signed [EW-1:0] eds;
    logic signed [EW-1:0] big_e;
    logic signed [EW-1:0] nclr;
    logic [23:0]          unit_full;
    logic [22:0]          lowmask;

    logic        spec_d;
    logic [31:0] spval_d;
    logic [22:0] man_d;
    logic        stk_d;
    logic [23:0] unit_d;

    logic        vld_p2_q;
    logic        spec_p2_q;
    logic [31:0] spval_p2_q;
    logic        sign_p2_q;
    logic [7:0]  expo_p2_q;
    logic [22:0] man_p2_q;
    logic        stk_p2_q;
    logic [23:0] unit_p2_q;

    always_comb begin
        exp_ext   = {{(EW-8){1'b0}}, exp_p1_q};
        shf_ext   = {{(EW-SHIFT_W){1'b0}}, shf_p1_q};
        eds       = exp_ext - shf_ext;
        big_e     = eds - BIAS;
        nclr      = M_BITS - big_e;
        unit_full = 24'h1 << nclr;
        lowmask   = unit_full[22:0] - 23'd1;

        spec_d  = 1'b0;
        spval_d = 32'h0;
        man_d   = man_p1_q;
        stk_d   = 1'b0;
        unit_d  = 24'h0;
        case (cls_p1_q)
            CL_SPEC: begin
                spec_d  = 1'b1;
                spval_d = {sign_p1_q, exp_p1_q, man_p1_q};
            end
            CL_ZERO: begin
                spec_d = 1'b1;
                if (sign_p1_q) begin
                    // Negative denormals floor to -1 only in true-floor mode.
                    spval_d = (man_p1_q != 23'd0 && NEG_FLOOR != 0) ? NEG_ONE : NEG_ZERO;
                end
            end
            default: begin
                if (sign_p1_q && NEG_FLOOR == 0) begin
                    spec_d  = 1'b1;
                    spval_d = NEG_ZERO;
                end else if (big_e[EW-1]) begin
                    spec_d  = 1'b1;
                    spval_d = sign_p1_q ? NEG_ONE : 32'h0;
                end else if (big_e <= E_TOP) begin
                    man_d  = man_p1_q & ~lowmask;
                    stk_d  = |(man_p1_q & lowmask);
                    unit_d = unit_full;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2_q <= 1'b0;
        end else if (clk_en) begin
            vld_p2_q <= vld_p1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (clk_en && vld_p1_q) begin
            spec_p2_q  <= spec_d;
            spval_p2_q <= spval_d;
            sign_p2_q  <= sign_p1_q;
            expo_p2_q  <= eds[7:0];
            man_p2_q   <= man_d;
            stk_p2_q   <= stk_d;
            unit_p2_q  <= unit_d;
        end
    end

    // ---- stage 3: floor increment and output assembly
    logic        done_q;
    logic [31:0] result_q;
    logic [31:0] result_d;
    logic        bump_d;

    always_comb begin
        bump_d   = sign_p2_q && stk_p2_q && (NEG_FLOOR != 0);
        result_d = spec_p2_q ? spval_p2_q
                             : floor_assemble(sign_p2_q, expo_p2_q, man_p2_q, bump_d, unit_p2_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q   <= 1'b0;
            result_q <= 32'h0;
        end else if (clk_en) begin
            done_q <= vld_p2_q;
            if (vld_p2_q) begin
                result_q <= result_d;
            end
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_floor_div_pow2_mc.sv
// Directed bench for floor_div_pow2_mc: one instance per negative-input mode,
// both driven from the same stimulus.
module tb_floor_div_pow2_mc;

    logic        clk = 1'b0;
    logic        reset, clk_en, start;
    logic [31:0] dataa, datab;
    logic        done1, done0;
    logic [31:0] result1, result0;

    int n_chk  = 0;
    int n_fail = 0;

    floor_div_pow2_mc #(.NEG_FLOOR(1), .SHIFT_W(5)) dut1 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
        .dataa(dataa), .datab(datab), .done(done1), .result(result1)
    );

    floor_div_pow2_mc #(.NEG_FLOOR(0), .SHIFT_W(5)) dut0 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
        .dataa(dataa), .datab(datab), .done(done0), .result(result0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation, check exact 3-cycle latency and result hold afterwards.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp1, input logic [31:0] exp0);
        logic [31:0] held;
        dataa = a;
        datab = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        dataa = 32'hDEAD_BEEF;
        tick();
        chk({tag, " done early"}, {31'd0, done1}, 32'd0);
        tick();
        chk({tag, " done nf1"}, {31'd0, done1}, 32'd1);
        chk({tag, " done nf0"}, {31'd0, done0}, 32'd1);
        chk({tag, " result nf1"}, result1, exp1);
        chk({tag, " result nf0"}, result0, exp0);
        held = result1;
        tick();
        chk({tag, " done drop"}, {31'd0, done1}, 32'd0);
        chk({tag, " result hold"}, result1, held);
    endtask

    logic [31:0] seq_a [0:3];
    logic [31:0] seq_b [0:3];
    logic [31:0] pulse_res [0:7];
    int          pulse_cyc [0:7];
    int          npulse;
    logic        prev_en;
    int          late_done;

    initial begin
        reset  = 1'b1;
        clk_en = 1'b0;
        start  = 1'b1;
        dataa  = 32'h4120_0000;
        datab  = 32'd2;
        tick();
        tick();
        chk("reset done", {31'd0, done1}, 32'd0);
        chk("reset result", result1, 32'h0);

        reset  = 1'b0;
        clk_en = 1'b1;
        start  = 1'b0;
        late_done = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done1 || done0) late_done++;
        end
        chk("start during reset ignored", 32'(late_done), 32'd0);

        run_op("10.0 s2",    32'h4120_0000, 32'd2,        32'h4000_0000, 32'h4000_0000);
        run_op("-10.0 s2",   32'hC120_0000, 32'd2,        32'hC040_0000, 32'h8000_0000);
        run_op("-1.5 s0",    32'hBFC0_0000, 32'd0,        32'hC000_0000, 32'h8000_0000);
        run_op("-0.125 s3",  32'hBE00_0000, 32'd3,        32'hBF80_0000, 32'h8000_0000);
        run_op("7.0 s3",     32'h40E0_0000, 32'd3,        32'h0000_0000, 32'h0000_0000);
        run_op("NaN s5",     32'h7FC0_0000, 32'd5,        32'h7FC0_0000, 32'h7FC0_0000);
        run_op("-Inf s1",    32'hFF80_0000, 32'd1,        32'hFF80_0000, 32'hFF80_0000);
        run_op("-0 s1",      32'h8000_0000, 32'd1,        32'h8000_0000, 32'h8000_0000);
        run_op("+denorm",    32'h0000_0001, 32'd0,        32'h0000_0000, 32'h0000_0000);
        run_op("-denorm",    32'h8000_0001, 32'd0,        32'hBF80_0000, 32'h8000_0000);
        run_op("datab high", 32'h4120_0000, 32'hFFFF_FFE2, 32'h4000_0000, 32'h4000_0000);
        run_op("E=23 pos",   32'h4B7F_FFFF, 32'd0,        32'h4B7F_FFFF, 32'h4B7F_FFFF);
        run_op("E=23 neg",   32'hCB7F_FFFF, 32'd0,        32'hCB7F_FFFF, 32'h8000_0000);
        run_op("E=22 carry", 32'hCAFF_FFFF, 32'd0,        32'hCB00_0000, 32'h8000_0000);
        run_op("max s31",    32'h7F7F_FFFF, 32'd31,       32'h6FFF_FFFF, 32'h6FFF_FFFF);
        run_op("7.5 s0",     32'h40F0_0000, 32'd0,        32'h40E0_0000, 32'h40E0_0000);

        // Back-to-back issue with a one-cycle stall; the stalled-cycle start must be dropped.
        seq_a[0] = 32'h4120_0000; seq_b[0] = 32'd2;
        seq_a[1] = 32'hC120_0000; seq_b[1] = 32'd2;
        seq_a[2] = 32'h40F0_0000; seq_b[2] = 32'd0;
        seq_a[3] = 32'h3F80_0000; seq_b[3] = 32'd0;
        npulse  = 0;
        prev_en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            start  = (c <= 3);
            dataa  = (c <= 3) ? seq_a[c] : 32'h0;
            datab  = (c <= 3) ? seq_b[c] : 32'h0;
            clk_en = (c != 3);
            if (done1 && prev_en && npulse < 8) begin
                pulse_res[npulse] = result1;
                pulse_cyc[npulse] = c;
                npulse++;
            end
            if (c == 4) begin
                chk("stall hold done", {31'd0, done1}, 32'd1);
                chk("stall hold result", result1, 32'h4000_0000);
            end
            prev_en = clk_en;
            tick();
        end
        clk_en = 1'b1;
        start  = 1'b0;
        chk("pulse count", 32'(npulse), 32'd3);
        chk("pulse0 result", pulse_res[0], 32'h4000_0000);
        chk("pulse1 result", pulse_res[1], 32'hC040_0000);
        chk("pulse2 result", pulse_res[2], 32'h40E0_0000);
        chk("pulse0 cycle", 32'(pulse_cyc[0]), 32'd3);
        chk("pulse1 cycle", 32'(pulse_cyc[1]), 32'd5);
        chk("pulse2 cycle", 32'(pulse_cyc[2]), 32'd6);

        // Reset with two operations in flight.
        start = 1'b1;
        dataa = 32'hC120_0000;
        datab = 32'd2;
        tick();
        dataa = 32'h4120_0000;
        tick();
        start = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("flush done", {31'd0, done1}, 32'd0);
        chk("flush result", result1, 32'h0);
        late_done = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done1 || done0) late_done++;
        end
        chk("flush no pulse", 32'(late_done), 32'd0);
        chk("flush result held", result1, 32'h0);
        run_op("after flush", 32'h4120_0000, 32'd2, 32'h4000_0000, 32'h4000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/floor_div_pow2_mc.md
FLOOR_DIV_POW2_MC -- requirements
Module: floor_div_pow2_mc

Interface
REQ-001 The block SHALL have parameter NEG_FLOOR, default 1, selecting the negative-input mode: 1 = true floor toward minus infinity, 0 = legacy mode (negative input gives 0x80000000).
REQ-002 The block SHALL have parameter SHIFT_W, default 5, giving the width of the shift field taken from datab.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port clk_en, input, 1 bit: global advance enable; when 0, all stages hold.
REQ-006 The block SHALL have port start, input, 1 bit: launches one operation on a cycle where clk_en=1.
REQ-007 The block SHALL have port dataa, input, 32 bits: IEEE-754 single-precision operand x.
REQ-008 The block SHALL have port datab, input, 32 bits: shift amount s = datab[SHIFT_W-1:0]; all other bits are ignored.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking result valid for one operation.
REQ-010 The block SHALL have port result, output, 32 bits: floor(x / 2^s) as a single-precision value.

Function
REQ-011 The block SHALL be a 3-stage pipeline: S1 registers decode (sign, e, m, s, class); S2 computes E = e-127-s, the masked mantissa and the sticky bit (OR of cleared bits); S3 applies the increment and assembles the output.
REQ-012 done SHALL rise exactly 3 clk_en=1 cycles after the accepting start, with a one-start-per-cycle throughput; results SHALL return in issue order.
REQ-013 When clk_en=0, all valid bits, datapath registers, done and result SHALL hold their values; a start asserted while clk_en=0 SHALL be ignored.
REQ-014 result SHALL update only on cycles where done is asserted, and SHALL hold its value otherwise.
REQ-015 For e=255 (Inf/NaN), result SHALL equal dataa unchanged.
REQ-016 For e=0 (zero or denormal), handling SHALL be:
- +0 or positive denormal -> 0x00000000.
- -0 -> 0x80000000.
- Negative denormal -> 0xBF800000 (-1.0) when NEG_FLOOR=1, 0x80000000 when NEG_FLOOR=0.
REQ-017 For positive normal inputs, handling SHALL be:
- E<0 -> 0x00000000.
- 0<=E<=22 -> exponent e-s, mantissa with its low 23-E bits cleared.
- E>=23 -> exponent e-s, mantissa unchanged.
REQ-018 For negative normal inputs with NEG_FLOOR=0, result SHALL be 0x80000000.
REQ-019 For negative normal inputs with NEG_FLOOR=1, handling SHALL be:
- E<0 -> 0xBF800000.
- Otherwise truncate as in REQ-017; if sticky=1, add 2^(23-E) to the 24-bit significand {1,m}.
- Significand carry-out -> exponent +1, mantissa 0.
- Sign bit stays 1.
REQ-020 The exponent computation SHALL use at least 9-bit signed arithmetic so that e-s never wraps; s ranges over 0..2^SHIFT_W-1.
REQ-021 Bit 31 of result SHALL be 0 for every positive or +0 input.
REQ-022 Simultaneous start and done on the same cycle SHALL be legal: the new operation enters S1 while the completed one is presented.

Reset
REQ-023 While reset=1 at a clock edge, all stage valid bits SHALL clear, done SHALL be 0 and result SHALL be 0x00000000, regardless of clk_en.
REQ-024 Operations in flight when reset is asserted SHALL be discarded, producing no done pulse.
REQ-025 A start on the same cycle as reset=1 SHALL be ignored.
REQ-026 The first start accepted after reset deasserts SHALL complete normally at the latency given in REQ-012.

Verification
REQ-027 The bench SHALL cover: s=2, dataa=0x41200000 (10.0) -> done 3 cycles later, result 0x40000000 (2.0).
REQ-028 The bench SHALL cover: s=2, dataa=0xC1200000 (-10.0) -> result 0xC0400000 (-3.0) with NEG_FLOOR=1, and 0x80000000 with NEG_FLOOR=0.
REQ-029 The bench SHALL cover: s=0, dataa=0xBFC00000 (-1.5) -> result 0xC0000000 (carry into the exponent); s=3, dataa=0xBE000000 (-0.125) -> 0xBF800000.
REQ-030 The bench SHALL cover: s=3, dataa=0x40E00000 (7.0) -> 0x00000000; s=5, dataa=0x7FC00000 -> 0x7FC00000; dataa=0x80000000 -> 0x80000000.
REQ-031 The bench SHALL cover: starts on cycles 0,1,2 with clk_en=0 on cycle 3 -> exactly three done pulses, in issue order, the last delayed by one cycle.
REQ-032 The bench SHALL cover: reset=1 with two operations in flight -> no done pulse afterwards, result 0x00000000, and the next start completes after 3 cycles.
